// File: rtl/jtag_cfg_pkg.sv
// Shared types and field-layout helpers for the JTAG configuration data register.
package jtag_cfg_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_WRITE     = 2'b01,
        OP_READ      = 2'b10,
        OP_CLEAR_ERR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_WAIT_RD = 2'b10
    } state_e;

    localparam int OP_W = 2;

    // Total scan-path length: op + addr + data.
    function automatic int dr_width(input int addr_w, input int data_w);
        return OP_W + addr_w + data_w;
    endfunction

    // First bit of the address field.
    function automatic int addr_lsb();
        return OP_W;
    endfunction

    // First bit of the data field.
    function automatic int data_lsb(input int addr_w);
        return OP_W + addr_w;
    endfunction

endpackage

// File: rtl/jtag_cfg_shreg.sv
// Capture/shift register of the configuration DR, LSB shifted out first.
module jtag_cfg_shreg
    import jtag_cfg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 capture,
    input  logic                                 shift,
    input  logic                                 tdi,
    input  logic [dr_width(ADDR_W, DATA_W)-1:0]  cap_data,
    output logic                                 so,
    output logic [OP_W-1:0]                      op,
    output logic [ADDR_W-1:0]                    addr,
    output logic [DATA_W-1:0]                    data
);

    localparam int DR_W     = dr_width(ADDR_W, DATA_W);
    localparam int ADDR_LSB = addr_lsb();
    localparam int DATA_LSB = data_lsb(ADDR_W);

    logic [DR_W-1:0] sr_q;
    logic [DR_W-1:0] sr_d;

    // Next scan value: capture beats shift.
    always_comb begin
        sr_d = sr_q;
        if (capture) begin
            sr_d = cap_data;
        end else if (shift) begin
            sr_d = {tdi, sr_q[DR_W-1:1]};
        end
    end

    // Scan register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign so   = sr_q[0];
    assign op   = sr_q[ADDR_LSB-1:0];
    assign addr = sr_q[DATA_LSB-1:ADDR_LSB];
    assign data = sr_q[DR_W-1:DATA_LSB];

endmodule

// File: rtl/jtag_cfg_dr.sv
// JTAG user DR that turns a scanned {data, addr, op} command into one
// configuration-bus transaction and captures read data/status back.
module jtag_cfg_dr
    import jtag_cfg_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dr_sel,
    input  logic              capture_en,
    input  logic              shift_en,
    input  logic              update_en,
    input  logic              tdi,
    output logic              so,
    output logic              cfg_req_valid,
    input  logic              cfg_req_ready,
    output logic              cfg_req_write,
    output logic [ADDR_W-1:0] cfg_req_addr,
    output logic [DATA_W-1:0] cfg_req_data,
    input  logic              cfg_rd_valid,
    input  logic [DATA_W-1:0] cfg_rd_data,
    output logic              busy,
    output logic              error
);

    localparam int DR_W  = dr_width(ADDR_W, DATA_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Strobe qualification with capture > shift > update priority.
    logic do_capture;
    logic do_shift;
    logic do_update;

    assign do_capture = dr_sel & capture_en;
    assign do_shift   = dr_sel & shift_en & ~capture_en;
    assign do_update  = dr_sel & update_en & ~capture_en & ~shift_en;

    logic [OP_W-1:0]   sh_op;
    logic [ADDR_W-1:0] sh_addr;
    logic [DATA_W-1:0] sh_data;
    logic [DR_W-1:0]   cap_data;
    op_e               cmd_op;

    state_e            state_q,      state_d;
    logic              req_valid_q,  req_valid_d;
    logic              req_write_q,  req_write_d;
    logic [ADDR_W-1:0] req_addr_q,   req_addr_d;
    logic [DATA_W-1:0] req_data_q,   req_data_d;
    logic [ADDR_W-1:0] last_addr_q,  last_addr_d;
    logic [DATA_W-1:0] rd_data_q,    rd_data_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              busy_q,       busy_d;
    logic              error_q,      error_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              set_err;
    logic              clr_err;

    assign cap_data = {rd_data_q, last_addr_q, error_q, busy_q};
    assign cmd_op   = op_e'(sh_op);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    jtag_cfg_shreg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .capture  (do_capture),
        .shift    (do_shift),
        .tdi      (tdi),
        .cap_data (cap_data),
        .so       (so),
        .op       (sh_op),
        .addr     (sh_addr),
        .data     (sh_data)
    );

    // Transaction FSM, request payload, timeout counter and sticky error.
    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        last_addr_d = last_addr_q;
        rd_data_d   = rd_data_q;
        cnt_d       = cnt_q;
        set_err     = 1'b0;
        clr_err     = do_update && (cmd_op == OP_CLEAR_ERR);

        case (state_q)
            ST_IDLE: begin
                if (do_update && (cmd_op == OP_WRITE || cmd_op == OP_READ)) begin
                    state_d     = ST_REQ;
                    req_write_d = (cmd_op == OP_WRITE);
                    req_addr_d  = sh_addr;
                    req_data_d  = sh_data;
                    last_addr_d = sh_addr;
                end
            end
            ST_REQ: begin
                if (cfg_req_ready) begin
                    if (req_write_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_RD;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (cfg_rd_valid) begin
                    rd_data_d = cfg_rd_data;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A transaction command arriving while one is in flight is dropped.
        if (state_q != ST_IDLE && do_update &&
            (cmd_op == OP_WRITE || cmd_op == OP_READ)) begin
            set_err = 1'b1;
        end

        // Clear takes precedence over a simultaneous set.
        if (clr_err) begin
            error_d = 1'b0;
        end else if (set_err) begin
            error_d = 1'b1;
        end else begin
            error_d = error_q;
        end

        // Registered status outputs follow the next state.
        req_valid_d = (state_d == ST_REQ);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            last_addr_q <= '0;
            rd_data_q   <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            last_addr_q <= last_addr_d;
            rd_data_q   <= rd_data_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign cfg_req_valid = req_valid_q;
    assign cfg_req_write = req_write_q;
    assign cfg_req_addr  = req_addr_q;
    assign cfg_req_data  = req_data_q;
    assign busy          = busy_q;
    assign error         = error_q;

endmodule

// File: tb/tb_jtag_cfg_dr.sv
// Directed self-checking bench for jtag_cfg_dr (ADDR_W=DATA_W=32, TIMEOUT=16).
module tb_jtag_cfg_dr;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int DR_W = 2 + AW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          dr_sel;
    logic          capture_en;
    logic          shift_en;
    logic          update_en;
    logic          tdi;
    logic          so;
    logic          cfg_req_valid;
    logic          cfg_req_ready;
    logic          cfg_req_write;
    logic [AW-1:0] cfg_req_addr;
    logic [DW-1:0] cfg_req_data;
    logic          cfg_rd_valid;
    logic [DW-1:0] cfg_rd_data;
    logic          busy;
    logic          error;

    int checks = 0;
    int errors = 0;

    jtag_cfg_dr #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dr_sel        (dr_sel),
        .capture_en    (capture_en),
        .shift_en      (shift_en),
        .update_en     (update_en),
        .tdi           (tdi),
        .so            (so),
        .cfg_req_valid (cfg_req_valid),
        .cfg_req_ready (cfg_req_ready),
        .cfg_req_write (cfg_req_write),
        .cfg_req_addr  (cfg_req_addr),
        .cfg_req_data  (cfg_req_data),
        .cfg_rd_valid  (cfg_rd_valid),
        .cfg_rd_data   (cfg_rd_data),
        .busy          (busy),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Shift v in LSB first while recording what leaves on so.
    task automatic shift_vec(input logic [DR_W-1:0] v, output logic [DR_W-1:0] out);
        for (int i = 0; i < DR_W; i++) begin
            out[i]   = so;
            tdi      = v[i];
            shift_en = 1'b1;
            tick();
        end
        shift_en = 1'b0;
        tdi      = 1'b0;
    endtask

    task automatic do_update();
        update_en = 1'b1;
        tick();
        update_en = 1'b0;
    endtask

    task automatic do_capture();
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        dr_sel        = 1'b1;
        capture_en    = 1'b0;
        shift_en      = 1'b0;
        update_en     = 1'b0;
        tdi           = 1'b0;
        cfg_req_ready = 1'b0;
        cfg_rd_valid  = 1'b0;
        cfg_rd_data   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({so, cfg_req_valid, cfg_req_write, busy, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b expected 00000",
                     {so, cfg_req_valid, cfg_req_write, busy, error});
        end
        checks++;
        if ({cfg_req_addr, cfg_req_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_payload got %h expected 0", {cfg_req_addr, cfg_req_data});
        end
        // Ready high while idle must not produce a request.
        cfg_req_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (cfg_req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got valid=%b busy=%b expected 0 0", cfg_req_valid, busy);
        end
        cfg_req_ready = 1'b0;
    endtask

    task automatic test_write();
        logic [DR_W-1:0] dummy;
        shift_vec({32'hCAFE_F00D, 32'h0000_1000, 2'b01}, dummy);
        do_update();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) cfg_req_ready = 1'b1;
            checks++;
            if (cfg_req_valid !== 1'b1 || cfg_req_write !== 1'b1 || busy !== 1'b1 ||
                cfg_req_addr !== 32'h0000_1000 || cfg_req_data !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL write_hold cyc %0d got v=%b w=%b b=%b a=%h d=%h expected 1 1 1 00001000 cafef00d",
                         c, cfg_req_valid, cfg_req_write, busy, cfg_req_addr, cfg_req_data);
            end
            tick();
        end
        cfg_req_ready = 1'b0;
        checks++;
        if (cfg_req_valid !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL write_done got v=%b b=%b e=%b expected 0 0 0", cfg_req_valid, busy, error);
        end
    endtask

    task automatic test_read();
        logic [DR_W-1:0] dummy;
        logic [DR_W-1:0] got;
        shift_vec({32'h0, 32'h0000_0020, 2'b10}, dummy);
        cfg_req_ready = 1'b1;
        do_update();
        checks++;
        if (cfg_req_valid !== 1'b1 || cfg_req_write !== 1'b0 || cfg_req_addr !== 32'h20) begin
            errors++;
            $display("FAIL read_req got v=%b w=%b a=%h expected 1 0 00000020",
                     cfg_req_valid, cfg_req_write, cfg_req_addr);
        end
        tick();
        cfg_req_ready = 1'b0;
        tick();
        checks++;
        if (cfg_req_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_wait got v=%b b=%b expected 0 1", cfg_req_valid, busy);
        end
        cfg_rd_valid = 1'b1;
        cfg_rd_data  = 32'h1234_5678;
        tick();
        cfg_rd_valid = 1'b0;
        cfg_rd_data  = '0;
        checks++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL read_done got b=%b e=%b expected 0 0", busy, error);
        end
        do_capture();
        shift_vec('0, got);
        checks++;
        if (got !== {32'h1234_5678, 32'h0000_0020, 2'b00}) begin
            errors++;
            $display("FAIL read_capture got %h expected %h", got,
                     {32'h1234_5678, 32'h0000_0020, 2'b00});
        end
    endtask

    task automatic test_timeout();
        logic [DR_W-1:0] dummy;
        logic [DR_W-1:0] got;
        int early;
        shift_vec({32'h0, 32'h0000_0044, 2'b10}, dummy);
        cfg_req_ready = 1'b1;
        do_update();
        tick();
        cfg_req_ready = 1'b0;
        early = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (busy !== 1'b1 || error !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early got %0d bad cycles expected 0", early);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire got b=%b e=%b expected 0 1", busy, error);
        end
        do_capture();
        shift_vec('0, got);
        checks++;
        if (got !== {32'h1234_5678, 32'h0000_0044, 2'b10}) begin
            errors++;
            $display("FAIL timeout_capture got %h expected %h", got,
                     {32'h1234_5678, 32'h0000_0044, 2'b10});
        end
    endtask

    task automatic test_busy_collision();
        logic [DR_W-1:0] dummy;
        int hs;
        shift_vec({32'h0, 32'h0, 2'b11}, dummy);
        do_update();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_timeout got e=%b expected 0", error);
        end
        shift_vec({32'hAAAA_5555, 32'h0000_0300, 2'b01}, dummy);
        do_update();
        shift_vec({32'h1111_2222, 32'h0000_0400, 2'b01}, dummy);
        do_update();
        checks++;
        if (error !== 1'b1 || cfg_req_valid !== 1'b1 || cfg_req_addr !== 32'h300 ||
            cfg_req_data !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL collision got e=%b v=%b a=%h d=%h expected 1 1 00000300 aaaa5555",
                     error, cfg_req_valid, cfg_req_addr, cfg_req_data);
        end
        cfg_req_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            if (cfg_req_valid === 1'b1) hs++;
            tick();
        end
        cfg_req_ready = 1'b0;
        checks++;
        if (hs != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL collision_handshakes got %0d busy=%b expected 1 0", hs, busy);
        end
        shift_vec({32'h0, 32'h0, 2'b11}, dummy);
        do_update();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL clear_err got e=%b expected 0", error);
        end
    endtask

    task automatic test_select_gating();
        logic [DR_W-1:0] dummy;
        logic [DR_W-1:0] got;
        logic [DR_W-1:0] cmd;
        int so_changes;
        cmd = {32'h5A5A_0F0F, 32'h0000_0500, 2'b01};
        shift_vec(cmd, dummy);
        dr_sel     = 1'b0;
        so_changes = 0;
        for (int i = 0; i < DR_W; i++) begin
            tdi      = i[0];
            shift_en = 1'b1;
            tick();
            if (so !== 1'b1) so_changes++;
        end
        shift_en = 1'b0;
        tdi      = 1'b0;
        do_update();
        do_capture();
        tick();
        checks++;
        if (so_changes != 0 || cfg_req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gating got so_changes=%0d v=%b b=%b expected 0 0 0",
                     so_changes, cfg_req_valid, busy);
        end
        dr_sel = 1'b1;
        shift_vec('0, got);
        checks++;
        if (got !== cmd) begin
            errors++;
            $display("FAIL gating_sr got %h expected %h", got, cmd);
        end
    endtask

    task automatic test_reset_mid();
        logic [DR_W-1:0] dummy;
        logic [DR_W-1:0] got;
        shift_vec({32'h7777_8888, 32'h0000_0600, 2'b01}, dummy);
        do_update();
        checks++;
        if (cfg_req_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got v=%b b=%b expected 1 1", cfg_req_valid, busy);
        end
        reset = 1'b1;
        #2;
        checks++;
        if ({so, cfg_req_valid, cfg_req_write, busy, error} !== 5'b0 ||
            {cfg_req_addr, cfg_req_data} !== 64'h0) begin
            errors++;
            $display("FAIL async_reset got flags=%b a=%h d=%h expected 00000 0 0",
                     {so, cfg_req_valid, cfg_req_write, busy, error}, cfg_req_addr, cfg_req_data);
        end
        tick();
        reset        = 1'b0;
        cfg_rd_valid = 1'b1;
        cfg_rd_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        cfg_rd_valid = 1'b0;
        cfg_rd_data  = '0;
        do_capture();
        shift_vec('0, got);
        checks++;
        if (got !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL late_rd_valid got %h busy=%b expected 0 0", got, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_busy_collision();
        test_select_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
